// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath strobes.
module control_unit #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_rd,
    input  logic             update_flags,
    input  logic             ig_ex,
    input  logic             br_en,
    input  logic             br_link,
    input  logic             mem_op,
    input  logic             store_op,
    input  logic             sp_op,
    input  logic             primask_op,
    input  logic             exc_req,
    input  logic             halt_req,
    output logic             cu_decode,
    output logic             cu_execute,
    output logic             wr_en,
    output logic             branch,
    output logic             ld_pc,
    output logic             ld_lr,
    output logic             ld_sp,
    output logic             ld_rd,
    output logic             ld_apsr,
    output logic             ld_ipsr,
    output logic             ld_primask,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_count,
    output logic             halted
);

    // state   | meaning
    // RESET   | idle after reset, no strobes
    // FETCH   | instruction fetch, latched flags cleared on entry
    // DECODE  | decode strobe, ig_ex sampled into skip_q
    // EXECUTE | execute strobe, decode flags latched
    // MEM     | MEM_LAT cycles of memory access, wr_en for stores
    // WB      | register/PC loads, instruction retired
    // HALT    | parked until reset
    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    localparam logic [3:0] MEM_CNT_INIT = 4'(MEM_LAT - 1);

    typedef struct packed {
        logic write_rd;
        logic update_flags;
        logic br_en;
        logic br_link;
        logic mem_op;
        logic store_op;
        logic sp_op;
        logic primask_op;
    } flags_t;

    logic [2:0]       state_q, state_d;
    logic             skip_q, skip_d;
    flags_t           flags_q, flags_d;
    logic [3:0]       mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RESET;
            skip_q       <= 1'b0;
            flags_q      <= '0;
            mem_cnt_q    <= 4'd0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            flags_q      <= flags_d;
            mem_cnt_q    <= mem_cnt_d;
            inst_count_q <= inst_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = ig_ex ? S_WB : S_EXECUTE;
            S_EXECUTE: state_d = mem_op ? S_MEM : S_WB;
            S_MEM:     state_d = (mem_cnt_q == 4'd0) ? S_WB : S_MEM;
            S_WB:      state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_RESET;
        endcase
    end

    always_comb begin
        skip_d       = skip_q;
        flags_d      = flags_q;
        mem_cnt_d    = mem_cnt_q;
        inst_count_d = inst_count_q;
        case (state_q)
            S_DECODE: skip_d = ig_ex;
            S_EXECUTE: begin
                flags_d = '{write_rd, update_flags, br_en, br_link,
                            mem_op, store_op, sp_op, primask_op};
                if (mem_op) mem_cnt_d = MEM_CNT_INIT;
            end
            S_MEM: if (mem_cnt_q != 4'd0) mem_cnt_d = mem_cnt_q - 4'd1;
            S_WB:  inst_count_d = inst_count_q + CNT_W'(1);
            default: ;
        endcase
        // nothing from the previous instruction may survive into the next
        if (state_d == S_FETCH) begin
            skip_d  = 1'b0;
            flags_d = '0;
        end
    end

    always_comb begin
        cu_decode  = 1'b0;
        cu_execute = 1'b0;
        wr_en      = 1'b0;
        branch     = 1'b0;
        ld_pc      = 1'b0;
        ld_lr      = 1'b0;
        ld_sp      = 1'b0;
        ld_rd      = 1'b0;
        ld_apsr    = 1'b0;
        ld_ipsr    = 1'b0;
        ld_primask = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_DECODE:  cu_decode  = 1'b1;
            S_EXECUTE: cu_execute = 1'b1;
            S_MEM:     wr_en      = flags_q.mem_op & flags_q.store_op;
            S_WB: begin
                ld_pc   = 1'b1;
                ld_ipsr = exc_req;
                if (!skip_q) begin
                    branch     = flags_q.br_en;
                    ld_lr      = flags_q.br_en & flags_q.br_link;
                    ld_rd      = flags_q.write_rd & ~flags_q.store_op;
                    ld_apsr    = flags_q.update_flags;
                    ld_sp      = flags_q.sp_op;
                    ld_primask = flags_q.primask_op;
                end
            end
            S_HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign state      = state_q;
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expectations are queued as
// each instruction is issued and compared cycle by cycle.
module tb_control_unit;

    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic rst;
    logic write_rd, update_flags, ig_ex, br_en, br_link, mem_op, store_op;
    logic sp_op, primask_op, exc_req, halt_req;
    logic cu_decode, cu_execute, wr_en, branch, ld_pc, ld_lr, ld_sp, ld_rd;
    logic ld_apsr, ld_ipsr, ld_primask, halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] inst_count;

    always #5 clk = ~clk;

    control_unit #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .write_rd(write_rd), .update_flags(update_flags), .ig_ex(ig_ex),
        .br_en(br_en), .br_link(br_link), .mem_op(mem_op), .store_op(store_op),
        .sp_op(sp_op), .primask_op(primask_op), .exc_req(exc_req),
        .halt_req(halt_req),
        .cu_decode(cu_decode), .cu_execute(cu_execute), .wr_en(wr_en),
        .branch(branch), .ld_pc(ld_pc), .ld_lr(ld_lr), .ld_sp(ld_sp),
        .ld_rd(ld_rd), .ld_apsr(ld_apsr), .ld_ipsr(ld_ipsr),
        .ld_primask(ld_primask), .state(state), .inst_count(inst_count),
        .halted(halted)
    );

    // bit order: dec exe wr br pc lr sp rd apsr ipsr pm halted
    logic [11:0] obs;
    assign obs = {cu_decode, cu_execute, wr_en, branch, ld_pc, ld_lr, ld_sp,
                  ld_rd, ld_apsr, ld_ipsr, ld_primask, halted};

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] strb;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic wr, input logic uf, input logic ig,
                          input logic br, input logic lk, input logic mem,
                          input logic st, input logic sp, input logic pm,
                          input logic exc, input logic hlt);
        write_rd = wr; update_flags = uf; ig_ex = ig; br_en = br; br_link = lk;
        mem_op = mem; store_op = st; sp_op = sp; primask_op = pm;
        exc_req = exc; halt_req = hlt;
    endtask

    task automatic push(input logic [2:0] st, input logic [11:0] s);
        exp_t e;
        e.st = st; e.strb = s; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // expected cycles of one instruction, starting from the FETCH cycle
    task automatic push_instr;
        logic [11:0] w;
        push(3'd1, 12'h000);
        push(3'd2, 12'h800);
        w = '0;
        w[7] = 1'b1;
        w[2] = exc_req;
        if (!ig_ex) begin
            push(3'd3, 12'h400);
            if (mem_op) begin
                for (int i = 0; i < MEM_LAT; i++) begin
                    logic [11:0] m;
                    m = '0;
                    m[9] = store_op;
                    push(3'd4, m);
                end
            end
            w[8] = br_en;
            w[6] = br_en & br_link;
            w[5] = sp_op;
            w[4] = write_rd & ~store_op;
            w[3] = update_flags;
            w[1] = primask_op;
        end
        push(3'd5, w);
        exp_cnt++;
    endtask

    task automatic drain;
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("c%0d state", cyc), 64'(state), 64'(e.st));
            check($sformatf("c%0d strobes", cyc), 64'(obs), 64'(e.strb));
            check($sformatf("c%0d inst_count", cyc), 64'(inst_count), 64'(e.cnt));
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0,0,0,0,0,0,0,0,0,0,0);
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 64'(state), 64'd0);
        check("reset strobes", 64'(obs), 64'd0);
        check("reset count", 64'(inst_count), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // plain ALU op writing Rd
        set_in(1,0,0,0,0,0,0,0,0,0,0); push_instr; drain;
        // store through MEM
        set_in(1,0,0,0,0,1,1,0,0,0,0); push_instr; drain;
        // branch with link, flags, SP update
        set_in(1,1,0,1,1,0,0,1,0,0,0); push_instr; drain;
        // no branch afterwards: branch/ld_lr must drop
        set_in(0,0,0,0,1,0,0,0,1,0,0); push_instr; drain;
        // skipped instruction, exception still latched
        set_in(1,1,1,1,1,0,0,1,1,1,0); push_instr; drain;

        // reset in the 2nd MEM cycle of a store
        set_in(0,0,0,0,0,1,1,0,0,0,0);
        push(3'd1, 12'h000); push(3'd2, 12'h800); push(3'd3, 12'h400);
        push(3'd4, 12'h200);
        drain;
        check("mem2 state", 64'(state), 64'd4);
        check("mem2 wr_en", 64'(wr_en), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midmem rst state", 64'(state), 64'd0);
        check("midmem rst wr_en", 64'(wr_en), 64'd0);
        check("midmem rst count", 64'(inst_count), 64'd0);
        rst = 1'b0;
        exp_cnt = 0;
        set_in(1,0,0,0,0,0,0,0,0,0,0);
        @(posedge clk); #1;
        push_instr; drain;
        // load: Rd written, no write enable
        set_in(1,0,0,0,0,1,0,0,0,0,0); push_instr; drain;
        // third instruction halts with an exception pending
        set_in(1,0,0,0,0,0,0,0,0,1,1); push_instr; drain;
        for (int i = 0; i < 12; i++) push(3'd6, 12'h001);
        drain;
        check("halt count", 64'(inst_count), 64'd3);

        rst = 1'b1;
        @(posedge clk); #1;
        check("post-halt rst state", 64'(state), 64'd0);
        check("post-halt rst halted", 64'(halted), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-halt fetch", 64'(state), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
